// File: rtl/ps2_guess_receiver.sv
// ps2_guess_receiver
//   PS/2 keyboard front end for the whack-a-mole game. It deserialises
//   device-to-host frames, checks start/stop/odd parity, and decodes
//   make/break/extended scancodes into the same guess/evaluate/restart
//   strobes the button front end produces.
//
// Ports
//   clk          system clock (100 MHz)
//   rst_n        asynchronous active-low reset
//   ps2_clk      raw keyboard clock, asynchronous
//   ps2_data     raw keyboard data, asynchronous
//   user_guess   last decoded hole index 0..7 (keys 1..8)
//   eval_now     one-cycle strobe, user_guess must be evaluated
//   restart      one-cycle strobe, Enter pressed
//   frame_error  one-cycle strobe on bad start/stop/parity or mid-frame timeout
//
// Frame FSM
//   state    | meaning
//   F_IDLE   | waiting for the start-bit fall strobe
//   F_SHIFT  | collecting bits 1..10, watchdog running
//   F_CHECK  | one cycle: validate the 11-bit frame
//
// Decoder FSM
//   state       | meaning
//   D_NORMAL    | no prefix pending
//   D_BREAK     | 0xF0 seen, next byte is a release and is dropped
//   D_EXT       | 0xE0 seen, extended key follows
//   D_EXT_BREAK | 0xE0 0xF0 seen, next byte is dropped
module ps2_guess_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] user_guess,
  output logic       eval_now,
  output logic       restart,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {F_IDLE, F_SHIFT, F_CHECK} frame_state_t;
  typedef enum logic [1:0] {D_NORMAL, D_BREAK, D_EXT, D_EXT_BREAK} dec_state_t;

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_lvl_q, filt_lvl_d;
  logic          fall_q, fall_d;

  frame_state_t  frame_q, frame_d;
  logic [10:0]   sr_q, sr_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          frame_err_q, frame_err_d;
  logic          byte_valid;
  logic [7:0]    rx_byte;

  dec_state_t    dec_q, dec_d;
  logic [2:0]    guess_q, guess_d;
  logic          eval_q, eval_d;
  logic          restart_q, restart_d;
  logic          is_digit;
  logic [2:0]    digit_idx;

  // Synchroniser and glitch filter. The counter tracks how many consecutive
  // samples disagree with the current filtered level; any agreeing sample
  // clears it.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_cnt_d  = '0;
    filt_lvl_d  = filt_lvl_q;
    fall_d      = 1'b0;
    if (clk_sync_q[1] != filt_lvl_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_lvl_d = clk_sync_q[1];
        fall_d     = filt_lvl_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Bits enter at the top so that after 11 shifts the start bit sits in sr[0].
  always_comb begin
    frame_d     = frame_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    wdog_d      = wdog_q;
    frame_err_d = 1'b0;
    byte_valid  = 1'b0;
    case (frame_q)
      F_IDLE: begin
        wdog_d = '0;
        if (fall_q) begin
          sr_d      = {data_sync_q[1], sr_q[10:1]};
          bit_cnt_d = 4'd1;
          frame_d   = F_SHIFT;
        end
      end
      F_SHIFT: begin
        if (fall_q) begin
          sr_d      = {data_sync_q[1], sr_q[10:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          wdog_d    = '0;
          if (bit_cnt_q == 4'd10) frame_d = F_CHECK;
        end else if (wdog_q == WDOG_LAST) begin
          frame_err_d = 1'b1;
          frame_d     = F_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      F_CHECK: begin
        if (!sr_q[0] && sr_q[10] && (^sr_q[9:1])) byte_valid = 1'b1;
        else                                        frame_err_d = 1'b1;
        frame_d = F_IDLE;
      end
      default: frame_d = F_IDLE;
    endcase
  end

  assign rx_byte = sr_q[8:1];

  always_comb begin
    is_digit  = 1'b1;
    digit_idx = 3'd0;
    case (rx_byte)
      8'h16:   digit_idx = 3'd0;
      8'h1E:   digit_idx = 3'd1;
      8'h26:   digit_idx = 3'd2;
      8'h25:   digit_idx = 3'd3;
      8'h2E:   digit_idx = 3'd4;
      8'h36:   digit_idx = 3'd5;
      8'h3D:   digit_idx = 3'd6;
      8'h3E:   digit_idx = 3'd7;
      default: is_digit  = 1'b0;
    endcase
  end

  always_comb begin
    dec_d     = dec_q;
    guess_d   = guess_q;
    eval_d    = 1'b0;
    restart_d = 1'b0;
    if (byte_valid) begin
      case (dec_q)
        D_NORMAL: begin
          if (rx_byte == 8'hF0)      dec_d = D_BREAK;
          else if (rx_byte == 8'hE0) dec_d = D_EXT;
          else if (is_digit) begin
            guess_d = digit_idx;
            eval_d  = 1'b1;
          end else if (rx_byte == 8'h5A) begin
            restart_d = 1'b1;
          end
        end
        D_EXT:   dec_d = (rx_byte == 8'hF0) ? D_EXT_BREAK : D_NORMAL;
        default: dec_d = D_NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_cnt_q  <= '0;
      filt_lvl_q  <= 1'b1;
      fall_q      <= 1'b0;
      frame_q     <= F_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      wdog_q      <= '0;
      frame_err_q <= 1'b0;
      dec_q       <= D_NORMAL;
      guess_q     <= '0;
      eval_q      <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_cnt_q  <= filt_cnt_d;
      filt_lvl_q  <= filt_lvl_d;
      fall_q      <= fall_d;
      frame_q     <= frame_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      wdog_q      <= wdog_d;
      frame_err_q <= frame_err_d;
      dec_q       <= dec_d;
      guess_q     <= guess_d;
      eval_q      <= eval_d;
      restart_q   <= restart_d;
    end
  end

  assign user_guess  = guess_q;
  assign eval_now    = eval_q;
  assign restart     = restart_q;
  assign frame_error = frame_err_q;

endmodule

// File: tb/tb_ps2_guess_receiver.sv
module tb_ps2_guess_receiver;
  localparam int HALF = 20;
  localparam int TMO  = 1000;
  localparam int FLT  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [2:0] user_guess;
  logic       eval_now, restart, frame_error;

  ps2_guess_receiver #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .user_guess(user_guess), .eval_now(eval_now), .restart(restart),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   eval_cnt = 0, rst_cnt = 0, ferr_cnt = 0, wide_cnt = 0, excl_cnt = 0;
  int   strobe_cyc = 0;
  logic prev_e = 1'b0, prev_r = 1'b0, prev_f = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (eval_now)    eval_cnt++;
      if (restart)     rst_cnt++;
      if (frame_error) ferr_cnt++;
      if ((eval_now && prev_e) || (restart && prev_r) || (frame_error && prev_f)) wide_cnt++;
      if (eval_now && restart) excl_cnt++;
      if (eval_now || restart) strobe_cyc = cyc;
    end
    prev_e = eval_now;
    prev_r = restart;
    prev_f = frame_error;
  end

  int checks = 0, errors = 0;
  int stop_cyc = 0;

  // Reference model: pending prefix bytes and the last guess.
  logic [7:0] pfx[$];
  logic [2:0] m_guess = 3'd0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int digit_of(input logic [7:0] b);
    logic [7:0] keys [8];
    keys = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
    for (int k = 0; k < 8; k++) if (keys[k] == b) return k;
    return -1;
  endfunction

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input int kind);
    logic par, stp, sta;
    par = ~^b;
    if (kind == 1) par = ~par;
    stp = (kind == 2) ? 1'b0 : 1'b1;
    sta = (kind == 3) ? 1'b1 : 1'b0;
    return {stp, par, b, sta};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      stop_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] b, input int kind);
    int e0, r0, f0, ee, er, ef, d, lat;
    e0 = eval_cnt; r0 = rst_cnt; f0 = ferr_cnt;
    ee = 0; er = 0; ef = 0;
    send_bits(mk_frame(b, kind), 11);
    repeat (3 * HALF) @(posedge clk);
    #1;
    if (kind != 0) ef = 1;
    else if (pfx.size() != 0) begin
      if (pfx.size() == 1 && pfx[0] == 8'hE0 && b == 8'hF0) pfx.push_back(b);
      else pfx.delete();
    end else if (b == 8'hF0 || b == 8'hE0) pfx.push_back(b);
    else begin
      d = digit_of(b);
      if (d >= 0) begin
        m_guess = 3'(d);
        ee = 1;
      end else if (b == 8'h5A) er = 1;
    end
    chk($sformatf("eval_pulses byte=%02h kind=%0d", b, kind), eval_cnt - e0, ee);
    chk($sformatf("restart_pulses byte=%02h kind=%0d", b, kind), rst_cnt - r0, er);
    chk($sformatf("frame_error_pulses byte=%02h kind=%0d", b, kind), ferr_cnt - f0, ef);
    chk($sformatf("user_guess byte=%02h", b), int'(user_guess), int'(m_guess));
    if (ee != 0 || er != 0) begin
      lat = strobe_cyc - stop_cyc;
      chk($sformatf("strobe_latency_window lat=%0d", lat), int'(lat >= FLT && lat <= FLT + 10), 1);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_user_guess"}, int'(user_guess), 0);
    chk({tag, "_eval_now"}, int'(eval_now), 0);
    chk({tag, "_restart"}, int'(restart), 0);
    chk({tag, "_frame_error"}, int'(frame_error), 0);
  endtask

  initial begin
    logic [7:0] pool [11];
    logic [7:0] b;
    int e0, f0, kind;
    pool = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h5A, 8'hF0, 8'hE0};

    repeat (3) @(posedge clk);
    #1 chk_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    do_frame(8'h26, 0);
    do_frame(8'h3E, 0);
    do_frame(8'hF0, 0);
    do_frame(8'h3E, 0);
    do_frame(8'hE0, 0);
    do_frame(8'h16, 0);
    do_frame(8'h16, 0);
    do_frame(8'h3E, 0);
    do_frame(8'h5A, 0);
    do_frame(8'h1E, 1);
    do_frame(8'h1E, 0);
    do_frame(8'h1E, 0);
    // Prefix survives an errored frame.
    do_frame(8'hF0, 0);
    do_frame(8'h16, 2);
    do_frame(8'h16, 0);
    do_frame(8'h2E, 3);

    // Mid-frame stall.
    e0 = eval_cnt; f0 = ferr_cnt;
    send_bits(mk_frame(8'h25, 0), 4);
    repeat (TMO + 50) @(posedge clk);
    #1;
    chk("timeout_frame_error", ferr_cnt - f0, 1);
    chk("timeout_no_eval", eval_cnt - e0, 0);
    do_frame(8'h25, 0);

    for (int n = 0; n < 40; n++) begin
      b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 10)];
      kind = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 3)) : 0;
      do_frame(b, kind);
    end

    // Flush any pending prefix, then load a nonzero guess before reset.
    do_frame(8'h00, 0);
    do_frame(8'h3E, 0);
    send_bits(mk_frame(8'h36, 0), 4);
    #3 rst_n = 1'b0;
    #1 chk_outputs_zero("midframe_reset");
    pfx.delete();
    m_guess = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    e0 = eval_cnt; f0 = ferr_cnt;
    send_bits(mk_frame(8'h36, 0) >> 4, 7);
    repeat (TMO + 50) @(posedge clk);
    #1;
    chk("misaligned_frame_error", ferr_cnt - f0, 1);
    chk("misaligned_no_eval", eval_cnt - e0, 0);
    do_frame(8'h36, 0);

    chk("strobe_width_violations", wide_cnt, 0);
    chk("eval_restart_overlap", excl_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
